// File: rtl/instruction_cache_controller.sv
// Direct-mapped instruction cache: combinational lookup, line refill over a req/ack
// handshake, and a multi-cycle whole-cache invalidate.
module instruction_cache_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] instruction_address,
    input  logic                  flush,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  busy,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int WSEL_W = $clog2(WORDS_PER_LINE);
    localparam int OFF_W  = WSEL_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

    state_t                state;
    logic [NUM_LINES-1:0]  valid;
    logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_mem [NUM_LINES][WORDS_PER_LINE];
    logic [IDX_W-1:0]      fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic [WSEL_W-1:0]     beat;
    logic                  flush_pending;
    logic [IDX_W-1:0]      flush_idx;

    logic [TAG_W-1:0]  addr_tag;
    logic [IDX_W-1:0]  addr_idx;
    logic [WSEL_W-1:0] addr_word;
    logic              last_beat;
    logic              unused_byte_bits;

    assign addr_tag         = instruction_address[ADDR_WIDTH-1 -: TAG_W];
    assign addr_idx         = instruction_address[OFF_W +: IDX_W];
    assign addr_word        = instruction_address[2 +: WSEL_W];
    assign unused_byte_bits = ^instruction_address[1:0];
    assign last_beat        = (beat == WSEL_W'(WORDS_PER_LINE - 1));

    // Lookup is only meaningful in IDLE; refill and flush both mask it.
    assign hit         = (state == IDLE) && valid[addr_idx] && (tag_mem[addr_idx] == addr_tag);
    assign instruction = hit ? data_mem[addr_idx][addr_word] : '0;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            valid         <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            beat          <= '0;
            flush_pending <= 1'b0;
            flush_idx     <= '0;
            fill_idx      <= '0;
            fill_tag      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        state     <= FLUSH;
                        flush_idx <= '0;
                    end else if (!hit) begin
                        state           <= REFILL;
                        fill_idx        <= addr_idx;
                        fill_tag        <= addr_tag;
                        beat            <= '0;
                        mem_req         <= 1'b1;
                        mem_addr        <= {instruction_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        valid[addr_idx] <= 1'b0;
                    end
                end
                REFILL: begin
                    if (flush) flush_pending <= 1'b1;
                    if (mem_ack) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            valid[fill_idx] <= 1'b1;
                            mem_req         <= 1'b0;
                            // A flush seen on the final ack cycle still counts.
                            if (flush_pending || flush) begin
                                state     <= FLUSH;
                                flush_idx <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            mem_addr <= mem_addr + ADDR_WIDTH'(4);
                        end
                    end
                end
                FLUSH: begin
                    valid[flush_idx] <= 1'b0;
                    flush_idx        <= flush_idx + 1'b1;
                    if (flush_idx == IDX_W'(NUM_LINES - 1)) begin
                        state         <= IDLE;
                        flush_pending <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; validity alone decides whether they are used.
    always_ff @(posedge clk) begin
        if (rst_n && state == REFILL && mem_ack) begin
            data_mem[fill_idx][beat] <= mem_rdata;
            if (last_beat) tag_mem[fill_idx] <= fill_tag;
        end
    end
endmodule

// File: tb/tb_instruction_cache_controller.sv
// Directed bench for instruction_cache_controller: refill, conflict eviction, slow memory,
// address change during refill, flush (idle and mid-refill) and reset mid-refill.
module tb_instruction_cache_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction_address = '0;
    logic        flush = 1'b0;
    logic        hit;
    logic [31:0] instruction;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    instruction_cache_controller dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .instruction_address(instruction_address),
        .flush              (flush),
        .hit                (hit),
        .instruction        (instruction),
        .busy               (busy),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in IDLE with a miss on the current address; serves one line refill.
    task automatic serve_refill(input logic [31:0] base, input logic [3:0][31:0] words,
                                input int stall_beat, input int stall_n,
                                input int chg_beat, input logic [31:0] chg_addr,
                                input int flush_beat, input string name);
        mem_ack = 1'b0;
        step();
        for (int b = 0; b < 4; b++) begin
            if (b == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    checks++;
                    if ({mem_req, busy, hit, instruction, mem_addr} !== {3'b110, 32'h0, base + 32'(4 * b)}) begin
                        errors++;
                        $display("FAIL %s_stall beat %0d cyc %0d: req=%0b busy=%0b hit=%0b instr=%h addr=%h, want req=1 busy=1 hit=0 instr=0 addr=%h",
                                 name, b, s, mem_req, busy, hit, instruction, mem_addr, base + 32'(4 * b));
                    end
                    step();
                end
            end
            checks++;
            if ({mem_req, busy, hit, instruction, mem_addr} !== {3'b110, 32'h0, base + 32'(4 * b)}) begin
                errors++;
                $display("FAIL %s_beat%0d: req=%0b busy=%0b hit=%0b instr=%h addr=%h, want req=1 busy=1 hit=0 instr=0 addr=%h",
                         name, b, mem_req, busy, hit, instruction, mem_addr, base + 32'(4 * b));
            end
            if (b == chg_beat) instruction_address = chg_addr;
            if (b == flush_beat) flush = 1'b1;
            mem_ack   = 1'b1;
            mem_rdata = words[b];
            step();
            flush   = 1'b0;
            mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instruction_address = 32'h0;
        step();
        step();
        checks++;
        if ({hit, busy, mem_req, mem_addr} !== 35'h0) begin
            errors++;
            $display("FAIL reset_state: hit=%0b busy=%0b req=%0b addr=%h, want all 0", hit, busy, mem_req, mem_addr);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_miss: hit=%0b want 0", hit);
        end
    endtask

    task automatic test_basic_refill();
        serve_refill(32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 0, -1, 32'h0, -1, "basic");
        checks++;
        if ({busy, mem_req, hit, instruction} !== {3'b001, 32'h11}) begin
            errors++;
            $display("FAIL basic_hit0: busy=%0b req=%0b hit=%0b instr=%h, want 0 0 1 00000011", busy, mem_req, hit, instruction);
        end
        instruction_address = 32'h8;
        #1;
        checks++;
        if ({hit, instruction} !== {1'b1, 32'h33}) begin
            errors++;
            $display("FAIL basic_hit8: hit=%0b instr=%h, want 1 00000033", hit, instruction);
        end
        instruction_address = 32'hC;
        #1;
        checks++;
        if ({hit, instruction} !== {1'b1, 32'h44}) begin
            errors++;
            $display("FAIL basic_hitC: hit=%0b instr=%h, want 1 00000044", hit, instruction);
        end
    endtask

    task automatic test_conflict();
        instruction_address = 32'h100;
        #1;
        checks++;
        if ({hit, instruction} !== 33'h0) begin
            errors++;
            $display("FAIL conflict_miss: hit=%0b instr=%h, want 0 0", hit, instruction);
        end
        serve_refill(32'h100, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1, 0, -1, 32'h0, -1, "conflict");
        instruction_address = 32'h104;
        #1;
        checks++;
        if ({hit, instruction} !== {1'b1, 32'hA1}) begin
            errors++;
            $display("FAIL conflict_hit104: hit=%0b instr=%h, want 1 000000a1", hit, instruction);
        end
        instruction_address = 32'h0;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL conflict_evicted: hit=%0b want 0", hit);
        end
    endtask

    task automatic test_slow_memory();
        serve_refill(32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 5, -1, 32'h0, -1, "slow");
        instruction_address = 32'h4;
        #1;
        checks++;
        if ({hit, instruction} !== {1'b1, 32'h22}) begin
            errors++;
            $display("FAIL slow_hit4: hit=%0b instr=%h, want 1 00000022", hit, instruction);
        end
    endtask

    task automatic test_addr_change();
        instruction_address = 32'h100;
        serve_refill(32'h100, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1, 0, -1, 32'h0, -1, "chg_evict");
        instruction_address = 32'h0;
        serve_refill(32'h0, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 0, 1, 32'h40, -1, "chg");
        checks++;
        if ({busy, hit} !== 2'b00) begin
            errors++;
            $display("FAIL chg_miss40: busy=%0b hit=%0b, want 0 0", busy, hit);
        end
        serve_refill(32'h40, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, -1, 0, -1, 32'h0, -1, "line4");
        instruction_address = 32'h48;
        #1;
        checks++;
        if ({hit, instruction} !== {1'b1, 32'hB2}) begin
            errors++;
            $display("FAIL chg_hit48: hit=%0b instr=%h, want 1 000000b2", hit, instruction);
        end
        instruction_address = 32'h0;
        #1;
        checks++;
        if ({hit, instruction} !== {1'b1, 32'h11}) begin
            errors++;
            $display("FAIL chg_hit0: hit=%0b instr=%h, want 1 00000011", hit, instruction);
        end
    endtask

    task automatic test_flush();
        instruction_address = 32'h0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({busy, hit, instruction} !== {2'b10, 32'h0}) begin
                errors++;
                $display("FAIL flush_busy cyc %0d: busy=%0b hit=%0b instr=%h, want 1 0 0", i, busy, hit, instruction);
            end
            if (i == 5) flush = 1'b1;
            step();
            flush = 1'b0;
        end
        checks++;
        if ({busy, hit} !== 2'b00) begin
            errors++;
            $display("FAIL flush_done0: busy=%0b hit=%0b, want 0 0", busy, hit);
        end
        instruction_address = 32'h40;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL flush_miss40: hit=%0b want 0", hit);
        end
        serve_refill(32'h40, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, -1, 0, -1, 32'h0, 1, "flushrf");
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({busy, hit, mem_req} !== 3'b100) begin
                errors++;
                $display("FAIL flushrf_busy cyc %0d: busy=%0b hit=%0b req=%0b, want 1 0 0", i, busy, hit, mem_req);
            end
            step();
        end
        checks++;
        if ({busy, hit} !== 2'b00) begin
            errors++;
            $display("FAIL flushrf_done: busy=%0b hit=%0b, want 0 0", busy, hit);
        end
    endtask

    task automatic test_reset_mid_refill();
        instruction_address = 32'h0;
        step();
        for (int b = 0; b < 3; b++) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hE0 + 32'(b);
            step();
        end
        mem_ack = 1'b0;
        checks++;
        if ({mem_req, busy, mem_addr} !== {2'b11, 32'hC}) begin
            errors++;
            $display("FAIL rstmid_pre: req=%0b busy=%0b addr=%h, want 1 1 0000000c", mem_req, busy, mem_addr);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({mem_req, busy, hit, mem_addr} !== 35'h0) begin
            errors++;
            $display("FAIL rstmid_abort: req=%0b busy=%0b hit=%0b addr=%h, want all 0", mem_req, busy, hit, mem_addr);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_nopartial: hit=%0b want 0", hit);
        end
        serve_refill(32'h0, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, -1, 0, -1, 32'h0, -1, "restart");
        instruction_address = 32'h8;
        #1;
        checks++;
        if ({hit, instruction} !== {1'b1, 32'hD2}) begin
            errors++;
            $display("FAIL restart_hit8: hit=%0b instr=%h, want 1 000000d2", hit, instruction);
        end
    endtask

    initial begin
        test_reset();
        test_basic_refill();
        test_conflict();
        test_slow_memory();
        test_addr_change();
        test_flush();
        test_reset_mid_refill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
